// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES-128 round sequencer
// Owns the state register, steps the round datapath and trades state with the external S-box unit.
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [RW-1:0] rk_idx,
    input  logic [127:0]  rk_data,
    output logic          sb_req_valid,
    input  logic          sb_req_ready,
    output logic [127:0]  sb_req_data,
    input  logic          sb_rsp_valid,
    input  logic [127:0]  sb_rsp_data,
    output logic [127:0]  core_din,
    output logic [1:0]    core_sel,
    input  logic [127:0]  core_dout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK,
        S_SBREQ,
        S_SBWAIT,
        S_DONE
    } fsm_e;

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    fsm_e          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  sbuf_q, sbuf_d;
    logic [RW-1:0] round_q, round_d;
    logic          first_round;
    logic          last_round;

    assign first_round = (round_q == '0);
    assign last_round  = (round_q == LAST_ROUND);

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            sbuf_q  <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            sbuf_q  <= sbuf_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:   if (in_valid) fsm_d = S_ARK;
            S_ARK:    fsm_d = last_round ? S_DONE : S_SBREQ;
            S_SBREQ:  if (sb_req_ready) fsm_d = S_SBWAIT;
            S_SBWAIT: if (sb_rsp_valid) fsm_d = S_ARK;
            S_DONE:   if (out_ready) fsm_d = S_IDLE;
            default:  fsm_d = S_IDLE;
        endcase
    end

    // Responses arriving outside SBWAIT never touch sbuf.
    always_comb begin
        state_d = state_q;
        sbuf_d  = sbuf_q;
        round_d = round_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    round_d = '0;
                end
            end
            S_ARK: begin
                state_d = core_dout ^ rk_data;
                if (!last_round) round_d = round_q + RW'(1);
            end
            S_SBWAIT: if (sb_rsp_valid) sbuf_d = sb_rsp_data;
            default: ;
        endcase
    end

    always_comb begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        sb_req_valid = 1'b0;
        rk_idx       = '0;
        core_sel     = 2'b00;
        core_din     = '0;
        case (fsm_q)
            S_IDLE:  in_ready = 1'b1;
            S_ARK: begin
                rk_idx   = round_q;
                core_din = first_round ? state_q : sbuf_q;
                core_sel = first_round ? 2'b00 : (last_round ? 2'b10 : 2'b01);
            end
            S_SBREQ: sb_req_valid = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_data    = state_q;
    assign sb_req_data = state_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed bench for aes_round_sequencer
// Behavioural S-box unit, round datapath and key store surround the sequencer.
module tb_aes_round_sequencer;
    localparam int NR = 10;
    localparam int RW = 4;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [127:0]  in_data, out_data;
    logic [RW-1:0] rk_idx;
    logic [127:0]  rk_data;
    logic          sb_req_valid, sb_req_ready, sb_rsp_valid;
    logic [127:0]  sb_req_data, sb_rsp_data;
    logic [127:0]  core_din, core_dout;
    logic [1:0]    core_sel;

    logic [7:0]    sbox_t [0:255];
    logic [127:0]  rk_t [0:10];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            req_delay = 0;
    int            rsp_delay = 0;
    bit            spurious = 1'b0;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rk_idx(rk_idx), .rk_data(rk_data),
        .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready), .sb_req_data(sb_req_data),
        .sb_rsp_valid(sb_rsp_valid), .sb_rsp_data(sb_rsp_data),
        .core_din(core_din), .core_sel(core_sel), .core_dout(core_dout)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic logic [127:0] dp_model(input logic [127:0] d, input logic [1:0] sel);
        case (sel)
            2'b01:   return mix_columns(shift_rows(d));
            2'b10:   return shift_rows(d);
            default: return d;
        endcase
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt);
        logic [127:0] s;
        s = pt ^ rk_t[0];
        for (int r = 1; r < NR; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_t[r];
        return shift_rows(sub_bytes(s)) ^ rk_t[NR];
    endfunction

    assign core_dout = dp_model(core_din, core_sel);
    assign rk_data   = (rk_idx <= 4'd10) ? rk_t[rk_idx] : '0;

    task automatic init_models(input logic [127:0] key);
        logic [7:0]  av, inv, b, rcon;
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int a = 0; a < 256; a++) begin
            av = a[7:0]; inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gmul(av, x[7:0]) == 8'h01) inv = x[7:0];
            b = inv;
            sbox_t[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_t[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // S-box unit: grants after req_delay cycles, answers after rsp_delay wait cycles.
    initial begin
        int phase, cnt;
        logic [127:0] sub;
        phase = 0; cnt = 0; sub = '0;
        sb_req_ready = 1'b0; sb_rsp_valid = 1'b0; sb_rsp_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                phase = 0; cnt = 0; sb_req_ready = 1'b0; sb_rsp_valid = 1'b0;
            end else if (phase == 0) begin
                sb_rsp_valid = spurious;
                sb_rsp_data  = {4{$urandom}};
                if (sb_req_valid === 1'b1 && cnt >= req_delay) begin
                    sb_req_ready = 1'b1; sub = sub_bytes(sb_req_data); phase = 1; cnt = 0;
                end else begin
                    sb_req_ready = 1'b0;
                    if (sb_req_valid === 1'b1) cnt++;
                end
            end else begin
                sb_req_ready = 1'b0;
                if (cnt >= rsp_delay) begin
                    sb_rsp_valid = 1'b1; sb_rsp_data = sub; phase = 0; cnt = 0;
                end else begin
                    sb_rsp_valid = 1'b0; cnt++;
                end
            end
        end
    end

    task automatic wait_out(input int limit, input bit keep_valid, input logic [127:0] next_data,
                            output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < limit) begin
            @(negedge clk); lat++;
            if (lat == 1) begin in_valid = keep_valid; in_data = next_data; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({in_ready, out_valid, sb_req_valid} !== 3'b100) begin n_bad++;
            $display("FAIL reset_hs: got %b exp 100", {in_ready, out_valid, sb_req_valid}); end
        n_cmp++; if (rk_idx !== '0 || core_sel !== 2'b00) begin n_bad++;
            $display("FAIL reset_idx: rk_idx=%0d sel=%b exp 0/00", rk_idx, core_sel); end
        n_cmp++; if (out_data !== '0) begin n_bad++;
            $display("FAIL reset_state: got %h exp 0", out_data); end
        in_valid = 1'b1; in_data = FIPS_PT; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_data !== '0) begin n_bad++;
            $display("FAIL reset_wins: in_ready=%b state=%h exp 1/0", in_ready, out_data); end
    endtask

    task automatic test_fips_c1();
        int k, pulses, r;
        bit prev;
        logic [1:0] exp_sel;
        req_delay = 0; rsp_delay = 0; spurious = 1'b0; out_ready = 1'b1;
        in_data = FIPS_PT; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fips_accept: in_ready=%b exp 1", in_ready); end
        k = 0; pulses = 0; prev = 1'b0;
        while (out_valid !== 1'b1 && k < 60) begin
            @(negedge clk); k++;
            if (k == 1) in_valid = 1'b0;
            if (sb_req_valid === 1'b1 && !prev) pulses++;
            prev = (sb_req_valid === 1'b1);
            if ((k - 1) % 3 == 0 && (k - 1) / 3 <= NR) begin
                r = (k - 1) / 3;
                exp_sel = (r == 0) ? 2'b00 : ((r == NR) ? 2'b10 : 2'b01);
                n_cmp++; if (rk_idx !== RW'(r)) begin n_bad++;
                    $display("FAIL fips_rk_idx r%0d: got %0d exp %0d", r, rk_idx, r); end
                n_cmp++; if (core_sel !== exp_sel) begin n_bad++;
                    $display("FAIL fips_core_sel r%0d: got %b exp %b", r, core_sel, exp_sel); end
            end
        end
        n_cmp++; if (k !== 32) begin n_bad++; $display("FAIL fips_latency: got %0d exp 32", k); end
        n_cmp++; if (out_data !== FIPS_CT) begin n_bad++; $display("FAIL fips_ct: got %h exp %h", out_data, FIPS_CT); end
        n_cmp++; if (pulses !== 10) begin n_bad++; $display("FAIL fips_sb_pulses: got %0d exp 10", pulses); end
        @(negedge clk);
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++;
            $display("FAIL fips_idle: got %b exp 10", {in_ready, out_valid}); end
    endtask

    task automatic test_sbox_backpressure();
        int lat;
        req_delay = 2; rsp_delay = 4; spurious = 1'b1; out_ready = 1'b1;
        in_data = FIPS_PT; in_valid = 1'b1;
        wait_out(150, 1'b0, FIPS_PT, lat);
        n_cmp++; if (lat !== 92) begin n_bad++; $display("FAIL sbbp_latency: got %0d exp 92", lat); end
        n_cmp++; if (out_data !== FIPS_CT) begin n_bad++; $display("FAIL sbbp_ct: got %h exp %h", out_data, FIPS_CT); end
        @(negedge clk);
        req_delay = 0; rsp_delay = 0; spurious = 1'b0;
    endtask

    task automatic test_out_backpressure();
        int lat;
        out_ready = 1'b0;
        in_data = FIPS_PT; in_valid = 1'b1;
        wait_out(60, 1'b0, FIPS_PT, lat);
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL obp_latency: got %0d exp 32", lat); end
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if ({out_valid, in_ready} !== 2'b10) begin n_bad++;
                $display("FAIL obp_hs cyc%0d: got %b exp 10", i, {out_valid, in_ready}); end
            n_cmp++; if (out_data !== FIPS_CT) begin n_bad++;
                $display("FAIL obp_stable cyc%0d: got %h exp %h", i, out_data, FIPS_CT); end
            in_valid = i[0]; in_data = 128'h0;
            if (i == 4) begin in_valid = 1'b0; out_ready = 1'b1; end
            @(negedge clk);
        end
        n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_bad++;
            $display("FAIL obp_idle: got %b exp 10", {in_ready, out_valid}); end
        n_cmp++; if (out_data !== FIPS_CT) begin n_bad++;
            $display("FAIL obp_no_accept: got %h exp %h", out_data, FIPS_CT); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [127:0] exp0;
        exp0 = aes_ref(128'h0);
        out_ready = 1'b1; in_data = 128'h0; in_valid = 1'b1;
        wait_out(60, 1'b1, FIPS_PT, lat);
        n_cmp++; if (lat !== 32 || out_data !== exp0) begin n_bad++;
            $display("FAIL b2b_first: lat=%0d data=%h exp 32/%h", lat, out_data, exp0); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_gap: in_ready=%b exp 1", in_ready); end
        wait_out(60, 1'b0, FIPS_PT, lat);
        n_cmp++; if (lat !== 32 || out_data !== FIPS_CT) begin n_bad++;
            $display("FAIL b2b_second: lat=%0d data=%h exp 32/%h", lat, out_data, FIPS_CT); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int hs, k, lat;
        req_delay = 0; rsp_delay = 4; out_ready = 1'b1;
        in_data = FIPS_PT; in_valid = 1'b1;
        @(negedge clk); in_valid = 1'b0;
        hs = 0; k = 0;
        while (hs < 5 && k < 200) begin
            if (sb_req_valid === 1'b1 && sb_req_ready === 1'b1) hs++;
            @(negedge clk); k++;
        end
        @(negedge clk);
        n_cmp++; if (hs !== 5 || {sb_req_valid, out_valid, in_ready} !== 3'b000) begin n_bad++;
            $display("FAIL midrst_busy: hs=%0d hs_bits=%b exp 5/000", hs, {sb_req_valid, out_valid, in_ready}); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if ({in_ready, out_valid, sb_req_valid} !== 3'b100) begin n_bad++;
            $display("FAIL midrst_idle: got %b exp 100", {in_ready, out_valid, sb_req_valid}); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL midrst_state: got %h exp 0", out_data); end
        rsp_delay = 0;
        in_data = FIPS_PT; in_valid = 1'b1;
        wait_out(60, 1'b0, FIPS_PT, lat);
        n_cmp++; if (lat !== 32 || out_data !== FIPS_CT) begin n_bad++;
            $display("FAIL midrst_recover: lat=%0d data=%h exp 32/%h", lat, out_data, FIPS_CT); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        init_models(FIPS_KEY);
        test_reset();
        test_fips_c1();
        test_sbox_backpressure();
        test_out_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES-128 encryption controller that drives the combinational round datapath (ShiftRows/MixColumns, 2-bit sel) and performs AddRoundKey on its output.
- Sits between the block input interface and the round datapath. Holds the 128-bit state register and fetches round keys from the key store.
- SubBytes runs outside the round datapath, in the CIM S-box unit, reached through a request/response handshake.
- Emits the ciphertext with valid/ready.

Parameters:
- NR, 10, number of full rounds; the final round uses sel 2'b10.
- RW, 4, width of the round counter and rk_idx; must satisfy 2^RW > NR.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  plaintext valid.
- in_ready  out  1  sequencer can accept a block; high only in IDLE.
- in_data  in  128  plaintext, byte 0 at [127:120].
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer accepts the ciphertext.
- out_data  out  128  ciphertext (the state register).
- rk_idx  out  RW  round-key index, 0..NR.
- rk_data  in  128  round key for rk_idx; combinational in the same cycle.
- sb_req_valid  out  1  S-box request valid.
- sb_req_ready  in  1  S-box unit accepts the request.
- sb_req_data  out  128  state to substitute (the state register).
- sb_rsp_valid  in  1  S-box result valid.
- sb_rsp_data  in  128  substituted state.
- core_din  out  128  round datapath input.
- core_sel  out  2  round datapath select: 00 first round, 01 middle rounds, 10 last round.
- core_dout  in  128  round datapath output, combinational from core_din/core_sel.

Behaviour:
- Registers: state[127:0], sbuf[127:0], round[RW-1:0], FSM.
- FSM states: IDLE, ARK, SBREQ, SBWAIT, DONE.
- Reset (synchronous, overrides everything, valid mid-operation):
  - FSM=IDLE; state, sbuf, round all zero.
  - Outputs: in_ready=1, out_valid=0, sb_req_valid=0, rk_idx=0.
  - Any in-flight S-box response is dropped.
- IDLE: in_ready=1. On in_valid: state<=in_data, round<=0, go to ARK.
- ARK:
  - rk_idx=round.
  - core_din = state when round==0, otherwise sbuf.
  - core_sel = 00 when round==0, 10 when round==NR, otherwise 01.
  - state <= core_dout ^ rk_data.
  - If round==NR go to DONE; otherwise round<=round+1 and go to SBREQ.
- SBREQ: sb_req_valid=1, sb_req_data=state. Go to SBWAIT on sb_req_ready; hold otherwise.
- SBWAIT: on sb_rsp_valid, sbuf<=sb_rsp_data and go to ARK.
- sb_rsp_valid is ignored in every state except SBWAIT.
- DONE: out_valid=1, out_data=state. On out_ready go to IDLE. out_data is stable while out_valid && !out_ready.
- out_valid and in_ready are never high together. No new block is accepted before the ciphertext handshake completes.
- rk_idx and core_sel are don't-care outside ARK; drive them 0.
- Latency with zero-wait S-box (sb_req_ready=1, sb_rsp_valid in the first SBWAIT cycle):
  - Accept cycle T.
  - ARK round 0 at T+1; ARK round r at T+1+3r.
  - out_valid first high at T+3NR+2, i.e. T+32 for NR=10.
  - Each S-box stall cycle adds exactly one cycle.
- Simultaneous events:
  - in_valid in DONE is ignored (in_ready=0).
  - out_ready outside DONE has no effect.
  - rst together with a handshake: reset wins and the handshake does not complete.

Test Plan:
- FIPS-197 C.1 with bench models of the S-box, round datapath and key schedule: in_data=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+32.
- Control sequencing on the same run:
  - rk_idx in ARK cycles is 0,1,…,10.
  - core_sel is 00, then 01 nine times, then 10.
  - sb_req_valid pulses exactly 10 times.
- S-box backpressure: sb_req_ready low 2 cycles and sb_rsp_valid delayed 4 cycles on every round -> same ciphertext; out_valid at T+32+60; spurious sb_rsp_valid pulses in SBREQ/ARK are ignored.
- Output backpressure: out_ready low for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, in_valid pulses ignored. IDLE entered the cycle after out_ready=1.
- Back-to-back: two blocks (plaintext 0…0 and FIPS vector) offered continuously -> both ciphertexts correct and in order; second accept one cycle after the first output handshake.
- Reset mid-run: rst asserted during round 5 SBWAIT -> next cycle IDLE, out_valid=0, state=0. A following FIPS block encrypts correctly.
